// File: rtl/instr_decode_pkg.sv
// Shared definitions for the sequential instruction decoder: opcode/op codes,
// one-hot register selects, phase and state types, and instruction field positions.
package instr_decode_pkg;

   // Opcode field values (in[15:13])
   localparam logic [2:0] OPC_B    = 3'b001;
   localparam logic [2:0] OPC_BL   = 3'b010;
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   // Op field values (in[12:11]), interpreted per opcode
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;
   localparam logic [1:0] OP_MEM     = 2'b00;
   localparam logic [1:0] OP_B       = 2'b00;
   localparam logic [1:0] OP_BL      = 2'b11;

   // One-hot register selects driven on nsel
   localparam logic [2:0] NSEL_NONE = 3'b000;
   localparam logic [2:0] NSEL_RN   = 3'b001;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RM   = 3'b100;

   // Instruction field bit positions
   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 13;
   localparam int OP_MSB   = 12;
   localparam int OP_LSB   = 11;
   localparam int RN_MSB   = 10;
   localparam int RN_LSB   = 8;
   localparam int RD_MSB   = 7;
   localparam int RD_LSB   = 5;
   localparam int SH_MSB   = 4;
   localparam int SH_LSB   = 3;
   localparam int RM_MSB   = 2;
   localparam int RM_LSB   = 0;
   localparam int IMM8_MSB = 7;

   typedef enum logic [1:0] {
      PT_NONE = 2'd0,
      PT_RD   = 2'd1,
      PT_WR   = 2'd2
   } ph_type_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PH0  = 3'd1,
      ST_PH1  = 3'd2,
      ST_PH2  = 3'd3,
      ST_HALT = 3'd4
   } state_e;

   typedef struct packed {
      ph_type_e   ptype;
      logic [2:0] nsel;
      logic       last;
   } phase_t;

   function automatic phase_t mk_phase(input ph_type_e t, input logic [2:0] n, input logic l);
      phase_t p;
      p.ptype = t;
      p.nsel  = n;
      p.last  = l;
      return p;
   endfunction

endpackage

// File: rtl/sign_ext.sv
// Sign extension of an N-bit immediate to DW bits (X-free, pure replication).
module sign_ext #(
   parameter int N  = 8,
   parameter int DW = 16
) (
   input  logic [N-1:0]  i_val,
   output logic [DW-1:0] o_ext
);

   assign o_ext = {{(DW-N){i_val[N-1]}}, i_val};

endmodule

// File: rtl/instr_decode_seq.sv
// Registered multi-cycle instruction decoder. Accepts a 16-bit instruction by
// valid/ready, holds its fields, and presents one register-file phase per cycle.
// Optional feature: define DECODE_ILLEGAL_TRAP_EN to halt on undefined opcode/op
// instead of executing them as a one-phase NOP.
module instr_decode_seq
   import instr_decode_pkg::*;
#(
   parameter int DW        = 16,
   parameter int NREG      = 8,
   parameter int ISSUE_OVL = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [15:0]             in,
   output logic                    ph_valid,
   input  logic                    ph_ready,
   output logic                    ph_last,
   output logic [2:0]              nsel,
   output logic [$clog2(NREG)-1:0] readnum,
   output logic [$clog2(NREG)-1:0] writenum,
   output logic                    read_en,
   output logic                    write_en,
   output logic [2:0]              opcode,
   output logic [1:0]              op,
   output logic [2:0]              cond,
   output logic [1:0]              shift,
   output logic [DW-1:0]           sximm8,
   output logic [DW-1:0]           sximm5,
   output logic                    halted
);

   localparam int RW = $clog2(NREG);

`ifdef DECODE_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   state_e          r_state, w_state_nxt, w_acc_state;
   logic [2:0]      r_opcode, r_rn, r_rd, r_rm;
   logic [1:0]      r_op, r_shift;
   logic [7:0]      r_imm8;
   logic            r_ph_valid, r_ph_last, r_read_en, r_write_en, r_halted;
   logic [2:0]      r_nsel;
   logic [RW-1:0]   r_readnum, r_writenum;
   logic            w_fire, w_adv, w_load, w_issue, w_clear, w_in_legal;
   logic [1:0]      w_idx;
   logic [2:0]      w_opc_sel, w_rn_sel, w_rd_sel, w_rm_sel, w_regsel;
   logic [1:0]      w_op_sel;
   phase_t          w_desc;

   // Instruction codes that have a defined meaning; everything else is NOP or trap.
   function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] o);
      logic ok;
      case (opc)
         OPC_MOV:           ok = (o == OP_MOV_IMM) || (o == OP_MOV_REG);
         OPC_ALU, OPC_HALT: ok = 1'b1;
         OPC_LDR, OPC_STR:  ok = (o == OP_MEM);
         OPC_B:             ok = (o == OP_B);
         OPC_BL:            ok = (o == OP_BL);
         default:           ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Phase table: register access for phase number idx of instruction {opc,o}.
   function automatic phase_t phase_tbl(input logic [2:0] opc, input logic [1:0] o,
                                        input logic [1:0] idx);
      phase_t p;
      p = mk_phase(PT_NONE, NSEL_NONE, 1'b1);
      case (opc)
         OPC_MOV: begin
            if (o == OP_MOV_IMM)      p = mk_phase(PT_WR, NSEL_RN, 1'b1);
            else if (o == OP_MOV_REG) p = (idx == 2'd0) ? mk_phase(PT_RD, NSEL_RM, 1'b0)
                                                        : mk_phase(PT_WR, NSEL_RD, 1'b1);
            else                      p = mk_phase(PT_NONE, NSEL_NONE, 1'b1);
         end
         OPC_ALU: begin
            case (o)
               OP_ADD, OP_AND: begin
                  case (idx)
                     2'd0:    p = mk_phase(PT_RD, NSEL_RN, 1'b0);
                     2'd1:    p = mk_phase(PT_RD, NSEL_RM, 1'b0);
                     default: p = mk_phase(PT_WR, NSEL_RD, 1'b1);
                  endcase
               end
               OP_CMP:  p = (idx == 2'd0) ? mk_phase(PT_RD, NSEL_RN, 1'b0)
                                          : mk_phase(PT_RD, NSEL_RM, 1'b1);
               OP_MVN:  p = (idx == 2'd0) ? mk_phase(PT_RD, NSEL_RM, 1'b0)
                                          : mk_phase(PT_WR, NSEL_RD, 1'b1);
               default: p = mk_phase(PT_NONE, NSEL_NONE, 1'b1);
            endcase
         end
         OPC_LDR: begin
            if (o == OP_MEM) p = (idx == 2'd0) ? mk_phase(PT_RD, NSEL_RN, 1'b0)
                                               : mk_phase(PT_WR, NSEL_RD, 1'b1);
            else             p = mk_phase(PT_NONE, NSEL_NONE, 1'b1);
         end
         OPC_STR: begin
            if (o == OP_MEM) p = (idx == 2'd0) ? mk_phase(PT_RD, NSEL_RN, 1'b0)
                                               : mk_phase(PT_RD, NSEL_RD, 1'b1);
            else             p = mk_phase(PT_NONE, NSEL_NONE, 1'b1);
         end
         default: p = mk_phase(PT_NONE, NSEL_NONE, 1'b1);
      endcase
      return p;
   endfunction

   // A HALT instruction never lets a successor overlap its retirement.
   assign in_ready = (r_state == ST_IDLE) ||
                     ((ISSUE_OVL != 0) && r_ph_valid && r_ph_last && ph_ready &&
                      (r_opcode != OPC_HALT));
   assign w_fire     = in_valid && in_ready;
   assign w_adv      = r_ph_valid && ph_ready;
   assign w_in_legal = is_legal(in[OPC_MSB:OPC_LSB], in[OP_MSB:OP_LSB]);
   assign w_acc_state = (TRAP_EN && !w_in_legal) ? ST_HALT : ST_PH0;

   // Next state and phase-update control; a new instruction takes priority since
   // it can only be accepted in IDLE or as the current last phase retires.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_issue     = 1'b0;
      w_clear     = 1'b0;
      w_idx       = 2'd0;
      if (w_fire) begin
         w_load      = 1'b1;
         w_state_nxt = w_acc_state;
         w_issue     = (w_acc_state == ST_PH0);
         w_clear     = (w_acc_state != ST_PH0);
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_IDLE;
            ST_PH0, ST_PH1, ST_PH2: begin
               if (w_adv && r_ph_last) begin
                  w_clear     = 1'b1;
                  w_state_nxt = (r_opcode == OPC_HALT) ? ST_HALT : ST_IDLE;
               end else if (w_adv) begin
                  if (r_state == ST_PH0) begin
                     w_issue     = 1'b1;
                     w_idx       = 2'd1;
                     w_state_nxt = ST_PH1;
                  end else if (r_state == ST_PH1) begin
                     w_issue     = 1'b1;
                     w_idx       = 2'd2;
                     w_state_nxt = ST_PH2;
                  end else begin
                     w_clear     = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_state_nxt = r_state;
               end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: begin
               w_clear     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign w_opc_sel = w_load ? in[OPC_MSB:OPC_LSB] : r_opcode;
   assign w_op_sel  = w_load ? in[OP_MSB:OP_LSB]   : r_op;
   assign w_rn_sel  = w_load ? in[RN_MSB:RN_LSB]   : r_rn;
   assign w_rd_sel  = w_load ? in[RD_MSB:RD_LSB]   : r_rd;
   assign w_rm_sel  = w_load ? in[RM_MSB:RM_LSB]   : r_rm;
   assign w_desc    = phase_tbl(w_opc_sel, w_op_sel, w_idx);

   // Register number addressed by the upcoming phase.
   always_comb begin
      w_regsel = 3'd0;
      case (w_desc.nsel)
         NSEL_RN: w_regsel = w_rn_sel;
         NSEL_RD: w_regsel = w_rd_sel;
         NSEL_RM: w_regsel = w_rm_sel;
         default: w_regsel = 3'd0;
      endcase
   end

   // State register and sticky halt flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_halted <= r_halted || (w_state_nxt == ST_HALT);
      end
   end

   // Instruction fields, captured on accept and held while the instruction runs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_opcode <= 3'd0;
         r_op     <= 2'd0;
         r_rn     <= 3'd0;
         r_rd     <= 3'd0;
         r_rm     <= 3'd0;
         r_shift  <= 2'd0;
         r_imm8   <= 8'd0;
      end else if (w_load) begin
         r_opcode <= in[OPC_MSB:OPC_LSB];
         r_op     <= in[OP_MSB:OP_LSB];
         r_rn     <= in[RN_MSB:RN_LSB];
         r_rd     <= in[RD_MSB:RD_LSB];
         r_rm     <= in[RM_MSB:RM_LSB];
         r_shift  <= in[SH_MSB:SH_LSB];
         r_imm8   <= in[IMM8_MSB:0];
      end
   end

   // Registered phase outputs: load the next phase, clear when idle/halted, else hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ph_valid <= 1'b0;
         r_ph_last  <= 1'b0;
         r_nsel     <= NSEL_NONE;
         r_read_en  <= 1'b0;
         r_write_en <= 1'b0;
         r_readnum  <= {RW{1'b0}};
         r_writenum <= {RW{1'b0}};
      end else if (w_issue) begin
         r_ph_valid <= 1'b1;
         r_ph_last  <= w_desc.last;
         r_nsel     <= w_desc.nsel;
         r_read_en  <= (w_desc.ptype == PT_RD);
         r_write_en <= (w_desc.ptype == PT_WR);
         r_readnum  <= (w_desc.ptype == PT_RD) ? RW'(w_regsel) : {RW{1'b0}};
         r_writenum <= (w_desc.ptype == PT_WR) ? RW'(w_regsel) : {RW{1'b0}};
      end else if (w_clear) begin
         r_ph_valid <= 1'b0;
         r_ph_last  <= 1'b0;
         r_nsel     <= NSEL_NONE;
         r_read_en  <= 1'b0;
         r_write_en <= 1'b0;
         r_readnum  <= {RW{1'b0}};
         r_writenum <= {RW{1'b0}};
      end
   end

   sign_ext #(.N(8), .DW(DW)) u_sx8 (.i_val(r_imm8),      .o_ext(sximm8));
   sign_ext #(.N(5), .DW(DW)) u_sx5 (.i_val(r_imm8[4:0]), .o_ext(sximm5));

   assign ph_valid = r_ph_valid;
   assign ph_last  = r_ph_last;
   assign nsel     = r_nsel;
   assign readnum  = r_readnum;
   assign writenum = r_writenum;
   assign read_en  = r_read_en;
   assign write_en = r_write_en;
   assign opcode   = r_opcode;
   assign op       = r_op;
   assign cond     = r_rn;
   assign shift    = r_shift;
   assign halted   = r_halted;

endmodule
